// File: rtl/nav_msg_gen.sv
// nav_msg_gen: byte FIFO serialized MSB-first into navigation message bits,
// one bit every EPOCHS_PER_BIT code epochs, so data edges align to code-period starts.
module nav_msg_gen #(
  parameter int   EPOCHS_PER_BIT = 20,
  parameter int   FIFO_DEPTH     = 4,
  parameter logic IDLE_BIT       = 1'b0,
  localparam int  AW             = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  input  logic          ena_in,
  input  logic          epoch_in,
  input  logic          wr_en_in,
  input  logic [7:0]    wr_data_in,
  input  logic          flush_in,
  input  logic          clr_flags_in,
  output logic          msg_out,
  output logic          bit_strobe_out,
  output logic          full_out,
  output logic [AW:0]   fill_out,
  output logic          underrun_out,
  output logic          overflow_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [2:0]    rem_q, rem_d;
  logic          msg_q, msg_d, stb_q, stb_d, ufl_q, ufl_d, ofl_q, ofl_d;
  logic          boundary, have_bits, fifo_ne, full, pop, wr_ok;
  logic [7:0]    rd_byte;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = !ena_in ? IDLE : (state_q == IDLE && epoch_in) ? RUN : state_q;
  // Pop and overflow decisions see pre-edge occupancy; a full FIFO popping this cycle still takes the write.
  assign boundary  = ena_in && epoch_in && (state_q == IDLE || cnt_q == 8'(EPOCHS_PER_BIT - 1));
  assign have_bits = rem_q != 3'd0;
  assign fifo_ne   = fill_q != '0;
  assign full      = fill_q == (AW+1)'(FIFO_DEPTH);
  assign pop       = boundary && !have_bits && fifo_ne;
  assign wr_ok     = wr_en_in && !flush_in && (!full || pop);
  assign rd_byte   = mem[rd_q];
  always_comb begin
    cnt_d  = (!ena_in || boundary) ? 8'd0 : epoch_in ? cnt_q + 8'd1 : cnt_q;
    msg_d  = !ena_in ? IDLE_BIT : !boundary ? msg_q : have_bits ? sh_q[6] : fifo_ne ? rd_byte[7] : IDLE_BIT;
    sh_d   = !boundary ? sh_q : have_bits ? {sh_q[5:0], 1'b0} : rd_byte[6:0];
    rem_d  = (!ena_in || flush_in) ? 3'd0 : !boundary ? rem_q : have_bits ? rem_q - 3'd1 : fifo_ne ? 3'd7 : 3'd0;
    stb_d  = boundary;
    rd_d   = flush_in ? '0 : rd_q + AW'(pop);
    wr_d   = flush_in ? '0 : wr_q + AW'(wr_ok);
    fill_d = flush_in ? '0 : fill_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    ufl_d  = (boundary && !have_bits && !fifo_ne) || (ufl_q && !clr_flags_in);
    ofl_d  = (wr_en_in && !flush_in && full && !pop) || (ofl_q && !clr_flags_in);
  end
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      rem_q  <= '0;
      msg_q  <= IDLE_BIT;
      stb_q  <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      ufl_q  <= 1'b0;
      ofl_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      msg_q  <= msg_d;
      stb_q  <= stb_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      fill_q <= fill_d;
      ufl_q  <= ufl_d;
      ofl_q  <= ofl_d;
    end
  always_ff @(posedge clk_in)
    if (wr_ok) mem[wr_q] <= wr_data_in;
  assign msg_out        = msg_q;
  assign bit_strobe_out = stb_q;
  assign full_out       = full;
  assign fill_out       = fill_q;
  assign underrun_out   = ufl_q;
  assign overflow_out   = ofl_q;
endmodule

// File: tb/tb_nav_msg_gen.sv
// tb_nav_msg_gen: directed vectors for nav_msg_gen with hand-computed expectations.
module tb_nav_msg_gen;
  localparam int EPB = 20;
  logic       clk, rst_n, ena, epoch, wr_en, flush, clr;
  logic [7:0] wr_data;
  logic       msg, stb, full, under, over;
  logic [2:0] fill;
  int         errors = 0, checks = 0;

  nav_msg_gen dut (
    .clk_in(clk), .rst_in_n(rst_n), .ena_in(ena), .epoch_in(epoch),
    .wr_en_in(wr_en), .wr_data_in(wr_data), .flush_in(flush), .clr_flags_in(clr),
    .msg_out(msg), .bit_strobe_out(stb), .full_out(full), .fill_out(fill),
    .underrun_out(under), .overflow_out(over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ep();
    epoch = 1'b1;
    tick();
    epoch = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // one full bit period: boundary epoch then EPB-1 holding epochs, 10 clocks apart
  task automatic bnd(input string tag, input logic exp);
    ep();
    chk({tag, "_stb"}, 32'(stb), 32'd1);
    chk({tag, "_msg"}, 32'(msg), 32'(exp));
    repeat (9) tick();
    for (int e = 1; e < EPB; e++) begin
      ep();
      chk({tag, "_hold_stb"}, 32'(stb), 32'd0);
      chk({tag, "_hold_msg"}, 32'(msg), 32'(exp));
      repeat (9) tick();
    end
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; ena = 0; epoch = 0; wr_en = 0; wr_data = 0; flush = 0; clr = 0;
    #12;
    chk("rst_msg", 32'(msg), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_under", 32'(under), 0);
    chk("rst_over", 32'(over), 0);
    tick();
    rst_n = 1'b1;
    tick();

    wr(8'h8B);
    chk("t2_fill1", 32'(fill), 1);
    ena = 1'b1;
    tick();
    chk("t2_idle_nostb", 32'(stb), 0);
    b = 8'h8B;
    for (int i = 7; i >= 0; i--) begin
      bnd($sformatf("t2_bit%0d", i), b[i]);
      if (i == 7) chk("t2_fill0", 32'(fill), 0);
    end
    ena = 1'b0;
    tick();
    chk("t2_dis_msg", 32'(msg), 0);

    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    chk("t3_notfull", 32'(full), 0);
    wr(8'hA4);
    chk("t3_full", 32'(full), 1);
    chk("t3_fill4", 32'(fill), 4);
    chk("t3_noover", 32'(over), 0);
    wr(8'hA5);
    chk("t3_over", 32'(over), 1);
    chk("t3_fill_kept", 32'(fill), 4);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr", 32'(over), 0);
    clr = 1'b1; wr(8'hA6); clr = 1'b0;
    chk("t3_set_wins", 32'(over), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    flush = 1'b1; wr(8'hA7); flush = 1'b0;
    chk("t3_flush", 32'(fill), 0);
    chk("t3_flush_full", 32'(full), 0);
    chk("t3_flush_noover", 32'(over), 0);

    wr(8'h5A);
    ena = 1'b1;
    b = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      bnd($sformatf("t4_bit%0d", i), b[i]);
      chk("t4_no_under", 32'(under), 0);
    end
    bnd("t4_underrun", 1'b0);
    chk("t4_under", 32'(under), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr", 32'(under), 0);
    ena = 1'b0;
    tick();

    wr(8'hE3); wr(8'h3C);
    ena = 1'b1;
    bnd("t5_e3_7", 1'b1); bnd("t5_e3_6", 1'b1); bnd("t5_e3_5", 1'b1);
    ena = 1'b0;
    tick();
    chk("t5_dis_msg", 32'(msg), 0);
    ep();
    chk("t5_dis_ep_stb", 32'(stb), 0);
    chk("t5_dis_ep_msg", 32'(msg), 0);
    ena = 1'b1;
    tick();
    chk("t5_reen_nostb", 32'(stb), 0);
    chk("t5_fill1", 32'(fill), 1);
    bnd("t5_3c_7", 1'b0);
    chk("t5_popped", 32'(fill), 0);
    bnd("t5_3c_6", 1'b0); bnd("t5_3c_5", 1'b1);
    ena = 1'b0;
    tick();

    flush = 1'b1; tick(); flush = 1'b0;
    wr(8'hF0); wr(8'h0F); wr(8'hAA); wr(8'h55);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_fill4", 32'(fill), 4);
    ena = 1'b1;
    epoch = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    epoch = 1'b0; wr_en = 1'b0;
    chk("t6_fill_same", 32'(fill), 4);
    chk("t6_full", 32'(full), 1);
    chk("t6_noover", 32'(over), 0);
    chk("t6_stb", 32'(stb), 1);
    chk("t6_msg", 32'(msg), 1);
    repeat (9) tick();
    for (int e = 1; e < EPB; e++) begin
      ep();
      repeat (9) tick();
    end
    bnd("t6_f0_6", 1'b1);
    bnd("t6_f0_5", 1'b1);
    wr(8'h99);
    chk("t6_over", 32'(over), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_arst_msg", 32'(msg), 0);
    chk("t6_arst_fill", 32'(fill), 0);
    chk("t6_arst_full", 32'(full), 0);
    chk("t6_arst_over", 32'(over), 0);
    chk("t6_arst_under", 32'(under), 0);
    chk("t6_arst_stb", 32'(stb), 0);
    tick();
    rst_n = 1'b1;
    ena = 1'b0;
    tick();
    wr(8'h80);
    chk("t6_post_fill", 32'(fill), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nav_msg_gen.md
Name: nav_msg_gen

Overview:
Navigation-message bit source that drives the msg_in input of the GPS signal generator core. Software loads message bytes over the register-bank UART path into a small byte FIFO. The block serializes them MSB-first at 50 bps, with every bit boundary aligned to a C/A code-epoch pulse from the core, so data-bit edges never fall mid-code-period.

Parameters:
EPOCHS_PER_BIT, 20, code epochs per message bit (1 ms epochs -> 50 bps); legal range 2..255
FIFO_DEPTH, 4, byte FIFO depth; power of two, >= 2
IDLE_BIT, 1'b0, value driven on msg_out when idle or on underrun

Ports:
clk_in  input  1  system clock
rst_in_n  input  1  asynchronous active-low reset
ena_in  input  1  general enable; low forces IDLE
epoch_in  input  1  one-cycle pulse at each C/A code period start
wr_en_in  input  1  byte write strobe
wr_data_in  input  8  byte to enqueue
flush_in  input  1  synchronous FIFO clear
clr_flags_in  input  1  clears underrun_out and overflow_out
msg_out  output  1  serialized message bit, to core msg_in
bit_strobe_out  output  1  one-cycle pulse when msg_out takes a new bit
full_out  output  1  FIFO full
fill_out  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
underrun_out  output  1  sticky: bit boundary occurred with no data
overflow_out  output  1  sticky: write attempted while full

Behaviour:
- Reset (async, rst_in_n=0): all outputs 0; msg_out=IDLE_BIT; FIFO empty; epoch counter=0; bit counter=0; state IDLE.
- States:
  - IDLE: waits for epoch_in while ena_in=1, then performs a bit load (below), clears the epoch counter, and moves to RUN.
  - RUN: on each epoch_in, if epoch counter = EPOCHS_PER_BIT-1, performs a bit load and resets the counter to 0; otherwise the counter increments.
  - ena_in=0 in any state: next cycle goes to IDLE; counters cleared; shift register emptied; msg_out=IDLE_BIT; FIFO contents retained.
- Bit load:
  - If the shift register holds remaining bits, shift out the next bit, MSB-first.
  - Else if the FIFO is non-empty, pop one byte and output its bit 7; 7 bits remain.
  - Else output IDLE_BIT and set underrun_out. Bits from a later byte start only at the next boundary.
- Latency: msg_out and bit_strobe_out update on the clock edge after the cycle in which the boundary epoch_in is sampled (1-cycle latency). bit_strobe_out fires on every load, including underrun loads.
- Bit period: exactly EPOCHS_PER_BIT epoch_in pulses between successive bit_strobe_out pulses. Clock cycles between epochs are irrelevant.
- epoch_in while ena_in=0 is ignored.
- FIFO:
  - Write accepted when not full.
  - Write while full is dropped and sets overflow_out.
  - Write and pop in the same cycle when full: both occur, fill unchanged, no overflow.
  - Pop decisions use pre-edge occupancy. A write into an empty FIFO on a boundary cycle is not popped that cycle, so that boundary is an underrun.
  - Pointers wrap modulo FIFO_DEPTH. fill_out ranges 0..FIFO_DEPTH; full_out = (fill_out == FIFO_DEPTH).
- flush_in: empties the FIFO and the shift register; does not change msg_out until the next load. If flush_in and wr_en_in are both high, flush wins and the write is discarded.
- clr_flags_in: clears both sticky flags. If clr_flags_in coincides with a new set event, the set wins.
- Reset asserted mid-byte: immediate return to reset values; the partial byte is lost.

Test Plan:
- Reset with all inputs 0 -> msg_out=0, fill_out=0, full_out=0, both flags 0.
- EPOCHS_PER_BIT=20, write 0x8B, ena_in=1, pulse epoch_in every 10 clocks -> msg_out sequence 1,0,0,0,1,0,1,1; each bit held exactly 20 epochs; bit_strobe_out 1 clock after each boundary epoch; fill_out goes 1 -> 0 at the first load.
- Write 5 bytes with FIFO_DEPTH=4 -> full_out=1 after the 4th write; 5th byte dropped; overflow_out=1; clr_flags_in clears it.
- Write 1 byte, run 9 boundaries -> 9th load outputs IDLE_BIT with a strobe; underrun_out=1.
- Deassert ena_in mid-byte (after 3 bits), re-enable -> msg_out=IDLE_BIT while disabled; after re-enable the first epoch loads bit 7 of the next FIFO byte.
- Full FIFO with a write on a boundary cycle -> fill stays 4, overflow_out stays 0; assert rst_in_n=0 mid-byte -> all outputs return to reset values asynchronously.
